pwm_gen: RTL and testbench
==========================

# pwm_gen

Duty-cycle generator that sits directly downstream of the 4-bit free-running counter. It consumes the counter's count value and produces a registered PWM waveform whose high time is set by a double-buffered duty register. Duty updates are glitch-free: they take effect only at a period boundary. The block also emits a period tick and keeps a running period count for the consumer stages that follow it.

## Interface
- WIDTH, 4, width of the incoming count; the PWM period is 2^WIDTH clocks.
- PCNT_W, 8, width of the period counter.

- clk  in  1  system clock, rising-edge active; the same clock drives the upstream counter.
- ARSTn  in  1  asynchronous reset, active-low.
- cnt_in  in  WIDTH  count from the upstream counter; advances by +1 per clock and wraps from all-ones to 0.
- duty_in  in  WIDTH+1  requested high time in clocks, 0..2^WIDTH; larger values saturate to 2^WIDTH.
- duty_ld  in  1  one-cycle strobe that captures duty_in into the pending register.
- duty_ack  out  1  one-cycle pulse when a pending duty becomes active.
- pwm_out  out  1  PWM waveform, registered.
- period_tick  out  1  one-cycle pulse marking the first clock of each period.
- period_cnt  out  PCNT_W  number of completed wraps, modulo 2^PCNT_W.

## Operation
- **Wrap detection**
  - prev_cnt holds cnt_in from the previous cycle.
  - wrap = (cnt_in < prev_cnt). This fires on the all-ones to 0 transition and also on any backward jump.
- **Duty double buffer**
  - duty_ld without wrap: pending <= sat(duty_in) and pend_v <= 1. If a value is already pending, the new one overwrites it (last write wins).
  - wrap with pend_v = 1: active <= pending, pend_v <= 0, duty_ack pulses.
  - duty_ld and wrap in the same cycle: sat(duty_in) goes straight to active. The old pending value is discarded, pend_v <= 0, and duty_ack pulses.
  - wrap with no pending value and no load: active is held and duty_ack stays 0.
- **PWM output**
  - eff_duty = the new active value on a wrap cycle; otherwise the current active value.
  - pwm_out <= (cnt_in < eff_duty), computed at WIDTH+1 bits and unsigned.
  - duty 0 gives a constant 0. Duty 2^WIDTH gives a constant 1.
- **Period tracking**
  - period_tick <= wrap.
  - period_cnt increments on each wrap and rolls over from 2^PCNT_W−1 to 0.
- **Reset (ARSTn low)**
  - Reset is immediate and asynchronous, including mid-period.
  - prev_cnt = all-ones. This matches the upstream counter's set value, so its first step to 0 counts as a wrap.
  - active = 0, pending = 0, pend_v = 0.
  - pwm_out = 0, period_tick = 0, duty_ack = 0, period_cnt = 0.
  - Any pending load is lost.

## Timing
- Latency from cnt_in to pwm_out is 1 clock. pwm_out for count k is visible in the cycle after cnt_in = k.
- period_tick and duty_ack are asserted in the same cycle as the pwm_out bit for count 0 of the new period.
- The earliest a new duty can reach pwm_out is the period that starts at the next wrap. A load that lands in the wrap cycle itself affects that period.
- The block has no combinational path from input to output.

## Structure
- Package pwm_pkg holds:
  - default WIDTH
  - DUTY_W = WIDTH+1
  - PCNT_W
  - the saturate function sat()
- Sub-module cnt_wrap_det: contains prev_cnt and the wrap compare, with a reset value of all-ones.
- Top-level pwm_gen: contains the buffers, the PWM compare and the period counter.

## Test plan
- **Reset and first wrap.** Hold ARSTn=0 with cnt_in=4'hF. Release, then step cnt_in 0,1,2… one per clock.
  - Required: all outputs 0 during reset.
  - Required: period_tick=1 exactly one clock after cnt_in=0, and period_cnt=1.
- **Steady duty.** Load duty 5, let it activate, and run one full period.
  - Required: pwm_out high for exactly 5 consecutive clocks, starting the cycle after cnt_in=0, and low for the remaining 11.
- **Extremes.** Load duty 0, then 16, then 31.
  - Required: duty 0 gives pwm_out constantly 0 for a whole period.
  - Required: duty 16 gives pwm_out constantly 1.
  - Required: duty 31 saturates and also gives constantly 1.
- **Mid-period load.** With duty 4 active, load 12 at cnt_in=7, then load 9 at cnt_in=10.
  - Required: the current period keeps 4 high clocks.
  - Required: the next period has 9 high clocks, and duty_ack pulses once at the wrap.
- **Simultaneous load and wrap.** Load 3 at cnt_in=5. Then, with cnt_in=0, strobe duty_ld with duty_in=10.
  - Required: that period has 10 high clocks and duty_ack pulses once.
- **Reset mid-period and rollover.**
  - Drop ARSTn at cnt_in=6. Required: pwm_out drops to 0 immediately, active=0, and the pending value is cleared.
  - Separately, run 256 periods. Required: period_cnt returns to 0.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared widths and the duty saturation helper for the PWM generator.
package pwm_pkg;

  localparam int WIDTH  = 4;
  localparam int DUTY_W = WIDTH + 1;
  localparam int PCNT_W = 8;

  // Clamp a requested high time to a full period of 2^w clocks.
  function automatic logic [31:0] sat(input logic [31:0] val, input int unsigned w);
    logic [31:0] lim;
    lim = 32'd1 << w;
    return (val > lim) ? lim : val;
  endfunction

endpackage

// File: rtl/cnt_wrap_det.sv
// Remembers the previous upstream count and flags any backward step as a wrap.
module cnt_wrap_det
  import pwm_pkg::*;
#(
  parameter int WIDTH = pwm_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             ARSTn,
  input  logic [WIDTH-1:0] cnt_in,
  output logic             o_wrap
);

  logic [WIDTH-1:0] r_prev_cnt;

  // Track last cycle's count; all-ones reset mirrors the upstream counter so
  // its first step to 0 is seen as a wrap.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge ARSTn) begin
    if (!ARSTn) r_prev_cnt <= '1;
    else        r_prev_cnt <= cnt_in;
  end

  assign o_wrap = (cnt_in < r_prev_cnt);

endmodule

// File: rtl/pwm_gen.sv
// PWM generator: double-buffered duty, registered compare output, period
// tick and running period count, all aligned to the upstream count wrap.
module pwm_gen
  import pwm_pkg::*;
#(
  parameter int WIDTH  = pwm_pkg::WIDTH,
  parameter int PCNT_W = pwm_pkg::PCNT_W
) (
  input  logic              clk,
  input  logic              ARSTn,
  input  logic [WIDTH-1:0]  cnt_in,
  input  logic [WIDTH:0]    duty_in,
  input  logic              duty_ld,
  output logic              duty_ack,
  output logic              pwm_out,
  output logic              period_tick,
  output logic [PCNT_W-1:0] period_cnt
);

  localparam int DW = WIDTH + 1;

  logic          w_wrap;
  logic [DW-1:0] w_duty_sat;
  logic [DW-1:0] w_eff_duty;
  logic [DW-1:0] r_active;
  logic [DW-1:0] r_pending;
  logic          r_pend_v;

  cnt_wrap_det #(
    .WIDTH (WIDTH)
  ) u_wrap_det (
    .clk    (clk),
    .ARSTn  (ARSTn),
    .cnt_in (cnt_in),
    .o_wrap (w_wrap)
  );

  assign w_duty_sat = DW'(sat(32'(duty_in), WIDTH));

  // Duty used for this cycle's compare: a wrap switches to the incoming
  // duty immediately so count 0 of the new period already uses it.
  // NOTE: the default assignment first guarantees no latch is inferred.
  always_comb begin
    w_eff_duty = r_active;
    if (w_wrap) begin
      if (duty_ld)       w_eff_duty = w_duty_sat;
      else if (r_pend_v) w_eff_duty = r_pending;
    end
  end

  // Double buffer: loads park in pending and promote only on a wrap; a load
  // on the wrap cycle bypasses pending and discards whatever was parked.
  always_ff @(posedge clk or negedge ARSTn) begin
    if (!ARSTn) begin
      r_active  <= '0;
      r_pending <= '0;
      r_pend_v  <= 1'b0;
      duty_ack  <= 1'b0;
    end else if (w_wrap) begin
      r_pend_v <= 1'b0;
      duty_ack <= duty_ld | r_pend_v;
      if (duty_ld)       r_active <= w_duty_sat;
      else if (r_pend_v) r_active <= r_pending;
    end else begin
      duty_ack <= 1'b0;
      if (duty_ld) begin
        r_pending <= w_duty_sat;
        r_pend_v  <= 1'b1;
      end
    end
  end

  // Registered PWM compare and period bookkeeping.
  always_ff @(posedge clk or negedge ARSTn) begin
    if (!ARSTn) begin
      pwm_out     <= 1'b0;
      period_tick <= 1'b0;
      period_cnt  <= '0;
    end else begin
      pwm_out     <= ({1'b0, cnt_in} < w_eff_duty);
      period_tick <= w_wrap;
      period_cnt  <= period_cnt + PCNT_W'(w_wrap);
    end
  end

endmodule

// File: tb/tb_pwm_gen.sv
// Self-checking bench for pwm_gen: a behavioural model pushes expected
// outputs per driven count, popped and compared after the clock edge.
module tb_pwm_gen;

  logic       clk = 1'b0;
  logic       ARSTn;
  logic [3:0] cnt_in;
  logic [4:0] duty_in;
  logic       duty_ld;
  logic       duty_ack;
  logic       pwm_out;
  logic       period_tick;
  logic [7:0] period_cnt;

  typedef struct {
    logic       pwm;
    logic       tick;
    logic       ack;
    logic [7:0] pcnt;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  int m_prev, m_active, m_pend, m_pcnt;
  bit m_pv;

  pwm_gen dut (
    .clk         (clk),
    .ARSTn       (ARSTn),
    .cnt_in      (cnt_in),
    .duty_in     (duty_in),
    .duty_ld     (duty_ld),
    .duty_ack    (duty_ack),
    .pwm_out     (pwm_out),
    .period_tick (period_tick),
    .period_cnt  (period_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int exp_mask(input int d);
    return (d >= 16) ? 'hFFFF : ((1 << d) - 1);
  endfunction

  task automatic model_reset();
    m_prev   = 15;
    m_active = 0;
    m_pend   = 0;
    m_pv     = 0;
    m_pcnt   = 0;
    sb.delete();
  endtask

  // Drive one count at the falling edge, predict, then compare after the rise.
  task automatic step(input int cnt, input bit ld, input int duty);
    exp_t e;
    exp_t g;
    int   s;
    bit   wrap;
    @(negedge clk);
    cnt_in  = 4'(cnt);
    duty_ld = ld;
    duty_in = 5'(duty);
    s    = (duty > 16) ? 16 : duty;
    wrap = (cnt < m_prev);
    e.ack = 1'b0;
    if (wrap) begin
      if (ld) begin
        m_active = s; m_pv = 0; e.ack = 1'b1;
      end else if (m_pv) begin
        m_active = m_pend; m_pv = 0; e.ack = 1'b1;
      end
    end else if (ld) begin
      m_pend = s; m_pv = 1;
    end
    e.pwm  = (cnt < m_active);
    e.tick = wrap;
    m_pcnt = (m_pcnt + int'(wrap)) % 256;
    e.pcnt = 8'(m_pcnt);
    m_prev = cnt;
    sb.push_back(e);
    @(posedge clk);
    #1;
    duty_ld = 1'b0;
    if (sb.size() == 0) begin
      check("sb_empty", 1, 0);
    end else begin
      g = sb.pop_front();
      check("pwm_out",     32'(pwm_out),     32'(g.pwm));
      check("period_tick", 32'(period_tick), 32'(g.tick));
      check("duty_ack",    32'(duty_ack),    32'(g.ack));
      check("period_cnt",  32'(period_cnt),  32'(g.pcnt));
    end
  endtask

  // One full period of counts 0..15 with up to two loads; ld_x < 0 means none.
  task automatic run_period(input int ld_a, input int da, input int ld_b, input int db,
                            output int mask, output int acks);
    mask = 0;
    acks = 0;
    for (int k = 0; k < 16; k++) begin
      step(k, (k == ld_a) || (k == ld_b), (k == ld_a) ? da : db);
      mask |= int'(pwm_out) << k;
      acks += int'(duty_ack);
    end
  endtask

  task automatic hold_reset();
    ARSTn   = 1'b0;
    cnt_in  = 4'hF;
    duty_ld = 1'b0;
    duty_in = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_pwm",  32'(pwm_out),     0);
    check("rst_tick", 32'(period_tick), 0);
    check("rst_ack",  32'(duty_ack),    0);
    check("rst_pcnt", 32'(period_cnt),  0);
    @(negedge clk);
    ARSTn = 1'b1;
  endtask

  initial begin
    int mask;
    int acks;

    // Reset and first wrap
    hold_reset();
    step(0, 1'b0, 0);
    check("first_tick", 32'(period_tick), 1);
    check("first_pcnt", 32'(period_cnt),  1);
    for (int k = 1; k < 16; k++) step(k, 1'b0, 0);

    // Steady duty 5
    run_period(3, 5, -1, 0, mask, acks);
    check("pre5_mask", mask, 0);
    run_period(-1, 0, -1, 0, mask, acks);
    check("duty5_mask", mask, exp_mask(5));
    check("duty5_ack",  acks, 1);
    run_period(-1, 0, -1, 0, mask, acks);
    check("duty5_hold_ack", acks, 0);

    // Extremes: 0, 16, 31
    run_period(2, 0, -1, 0, mask, acks);
    check("pre0_mask", mask, exp_mask(5));
    run_period(2, 16, -1, 0, mask, acks);
    check("duty0_mask", mask, 0);
    run_period(2, 31, -1, 0, mask, acks);
    check("duty16_mask", mask, 'hFFFF);
    run_period(2, 4, -1, 0, mask, acks);
    check("duty31_mask", mask, 'hFFFF);
    check("duty31_ack",  acks, 1);

    // Mid-period loads: 12 then 9 while duty 4 is active
    run_period(7, 12, 10, 9, mask, acks);
    check("mid_cur_mask", mask, exp_mask(4));
    run_period(-1, 0, -1, 0, mask, acks);
    check("mid_next_mask", mask, exp_mask(9));
    check("mid_next_ack",  acks, 1);

    // Simultaneous load and wrap
    run_period(5, 3, -1, 0, mask, acks);
    check("sim_pre_mask", mask, exp_mask(9));
    run_period(0, 10, -1, 0, mask, acks);
    check("sim_mask", mask, exp_mask(10));
    check("sim_ack",  acks, 1);
    run_period(-1, 0, -1, 0, mask, acks);
    check("sim_discard_mask", mask, exp_mask(10));
    check("sim_discard_ack",  acks, 0);

    // Reset mid-period with a pending load parked
    for (int k = 0; k <= 6; k++) step(k, k == 3, 13);
    check("pre_rst_pwm", 32'(pwm_out), 1);
    #2;
    ARSTn = 1'b0;
    #1;
    check("async_rst_pwm",  32'(pwm_out),    0);
    check("async_rst_pcnt", 32'(period_cnt), 0);
    hold_reset();
    run_period(-1, 0, -1, 0, mask, acks);
    check("post_rst_mask", mask, 0);
    check("post_rst_ack",  acks, 0);
    check("post_rst_pcnt", 32'(period_cnt), 1);

    // Period counter rollover: 256 wraps since reset
    for (int p = 0; p < 255; p++) run_period(-1, 0, -1, 0, mask, acks);
    check("rollover_pcnt", 32'(period_cnt), 0);
    check("sb_drained", 32'(sb.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
